// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch: walks a byte-wide synchronous-read memory, decodes length from byte 0.
// Define IMEM_BOUND_CHECK_EN to stop at MEM_DEPTH-1 and report imem_error_o instead of wrapping.
module fetch_sequencer #(
   parameter int unsigned       ADDR_W    = 64,
   parameter int unsigned       MEM_DEPTH = 1024,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic [7:0]        mem_rdata_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [3:0]        icode_o,
   output logic [3:0]        ifun_o,
   output logic [3:0]        rA_o,
   output logic [3:0]        rB_o,
   output logic [63:0]       valC_o,
   output logic [ADDR_W-1:0] valP_o,
   output logic              illegal_o,
   output logic              imem_error_o,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              halted_o,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_HALT} state_t;

`ifdef IMEM_BOUND_CHECK_EN
   localparam bit LP_CHK_EN = 1'b1;
`else
   localparam bit LP_CHK_EN = 1'b0;
`endif
   localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(MEM_DEPTH - 1);

   function automatic logic f_need_regids(input logic [3:0] ic);
      return ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
   endfunction

   function automatic logic f_need_valc(input logic [3:0] ic);
      return ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
   endfunction

   // Illegal opcodes are one byte long so they present straight after byte 0.
   function automatic logic [3:0] f_len(input logic [3:0] ic);
      if (ic > 4'hB) return 4'd1;
      return 4'd1 + {3'b000, f_need_regids(ic)} + (f_need_valc(ic) ? 4'd8 : 4'd0);
   endfunction

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
   logic                r_req, w_req_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [3:0]          r_req_idx, w_req_idx_nxt;
   logic                r_rsp_vld, w_rsp_vld_nxt;
   logic [3:0]          r_rsp_idx, w_rsp_idx_nxt;
   logic                r_oob, w_oob_nxt;
   logic [3:0]          r_icode, w_icode_nxt;
   logic [3:0]          r_ifun, w_ifun_nxt;
   logic [3:0]          r_ra, w_ra_nxt;
   logic [3:0]          r_rb, w_rb_nxt;
   logic [63:0]         r_valc, w_valc_nxt;
   logic [ADDR_W-1:0]   r_valp, w_valp_nxt;
   logic                r_illegal, w_illegal_nxt;
   logic                r_imem_err, w_imem_err_nxt;
   logic                r_valid, w_valid_nxt;
   logic                r_halted, w_halted_nxt;

   logic                w_fire;
   logic [3:0]          w_icode_eff;
   logic [3:0]          w_len;
   logic                w_regids;
   logic [2:0]          w_valc_j;
   logic [ADDR_W-1:0]   w_next_addr;
   logic                w_next_oob;
   logic                w_start;
   logic [ADDR_W-1:0]   w_start_pc;

   // Length is known combinationally in the cycle byte 0 returns.
   assign w_fire      = r_req & mem_gnt_i;
   assign w_icode_eff = (r_rsp_vld && r_rsp_idx == 4'd0) ? mem_rdata_i[7:4] : r_icode;
   assign w_len       = f_len(w_icode_eff);
   assign w_regids    = f_need_regids(w_icode_eff);
   assign w_valc_j    = 3'(r_rsp_idx - 4'd1 - {3'b000, w_regids});
   assign w_next_addr = r_addr + ADDR_W'(1);
   assign w_next_oob  = LP_CHK_EN && (w_next_addr > LP_MAX_ADDR);

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_nxt      = r_req;
      w_addr_nxt     = r_addr;
      w_req_idx_nxt  = r_req_idx;
      w_rsp_vld_nxt  = w_fire;
      w_rsp_idx_nxt  = r_req_idx;
      w_oob_nxt      = r_oob;
      w_icode_nxt    = r_icode;
      w_ifun_nxt     = r_ifun;
      w_ra_nxt       = r_ra;
      w_rb_nxt       = r_rb;
      w_valc_nxt     = r_valc;
      w_valp_nxt     = r_valp;
      w_illegal_nxt  = r_illegal;
      w_imem_err_nxt = r_imem_err;
      w_valid_nxt    = r_valid;
      w_halted_nxt   = r_halted;
      w_start        = 1'b0;
      w_start_pc     = r_pc;

      case (r_state)
         S_IDLE: begin
            w_start = 1'b1;
         end
         S_FETCH: begin
            // Byte 1 is requested speculatively before byte 0's data reveals the length.
            if (w_fire) begin
               if (r_req_idx == 4'd0 || (r_req_idx + 4'd1) < w_len) begin
                  if (w_next_oob) begin
                     w_req_nxt = 1'b0;
                     w_oob_nxt = 1'b1;
                  end else begin
                     w_addr_nxt    = w_next_addr;
                     w_req_idx_nxt = r_req_idx + 4'd1;
                  end
               end else begin
                  w_req_nxt = 1'b0;
               end
            end
            if (r_rsp_vld) begin
               if (r_rsp_idx == 4'd0) begin
                  w_icode_nxt   = mem_rdata_i[7:4];
                  w_ifun_nxt    = mem_rdata_i[3:0];
                  w_valp_nxt    = r_pc + ADDR_W'(w_len);
                  w_illegal_nxt = mem_rdata_i[7:4] > 4'hB;
               end else if (w_regids && r_rsp_idx == 4'd1) begin
                  w_ra_nxt = mem_rdata_i[7:4];
                  w_rb_nxt = mem_rdata_i[3:0];
               end else begin
                  w_valc_nxt[{w_valc_j, 3'b000} +: 8] = mem_rdata_i;
               end
               if (r_rsp_idx == (w_len - 4'd1)) begin
                  w_state_nxt = S_PRESENT;
                  w_valid_nxt = 1'b1;
                  w_req_nxt   = 1'b0;
               end else if (r_oob) begin
                  w_state_nxt    = S_PRESENT;
                  w_valid_nxt    = 1'b1;
                  w_req_nxt      = 1'b0;
                  w_imem_err_nxt = 1'b1;
               end
            end
         end
         S_PRESENT: begin
            if (instr_ready_i) begin
               if (r_icode == 4'h0 || r_illegal || r_imem_err) begin
                  w_state_nxt  = S_HALT;
                  w_valid_nxt  = 1'b0;
                  w_halted_nxt = 1'b1;
               end else begin
                  w_start    = 1'b1;
                  w_start_pc = redirect_valid_i ? redirect_pc_i : r_valp;
               end
            end
         end
         S_HALT: begin
            w_req_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_start) begin
         w_pc_nxt       = w_start_pc;
         w_addr_nxt     = w_start_pc;
         w_req_idx_nxt  = 4'd0;
         w_rsp_vld_nxt  = 1'b0;
         w_oob_nxt      = 1'b0;
         w_icode_nxt    = 4'h0;
         w_ifun_nxt     = 4'h0;
         w_ra_nxt       = 4'hF;
         w_rb_nxt       = 4'hF;
         w_valc_nxt     = '0;
         w_valp_nxt     = '0;
         w_illegal_nxt  = 1'b0;
         w_imem_err_nxt = 1'b0;
         if (LP_CHK_EN && (w_start_pc > LP_MAX_ADDR)) begin
            w_state_nxt    = S_PRESENT;
            w_valid_nxt    = 1'b1;
            w_imem_err_nxt = 1'b1;
            w_req_nxt      = 1'b0;
         end else begin
            w_state_nxt = S_FETCH;
            w_valid_nxt = 1'b0;
            w_req_nxt   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_req_idx  <= 4'd0;
         r_rsp_vld  <= 1'b0;
         r_rsp_idx  <= 4'd0;
         r_oob      <= 1'b0;
         r_icode    <= 4'h0;
         r_ifun     <= 4'h0;
         r_ra       <= 4'hF;
         r_rb       <= 4'hF;
         r_valc     <= '0;
         r_valp     <= '0;
         r_illegal  <= 1'b0;
         r_imem_err <= 1'b0;
         r_valid    <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_req      <= w_req_nxt;
         r_addr     <= w_addr_nxt;
         r_req_idx  <= w_req_idx_nxt;
         r_rsp_vld  <= w_rsp_vld_nxt;
         r_rsp_idx  <= w_rsp_idx_nxt;
         r_oob      <= w_oob_nxt;
         r_icode    <= w_icode_nxt;
         r_ifun     <= w_ifun_nxt;
         r_ra       <= w_ra_nxt;
         r_rb       <= w_rb_nxt;
         r_valc     <= w_valc_nxt;
         r_valp     <= w_valp_nxt;
         r_illegal  <= w_illegal_nxt;
         r_imem_err <= w_imem_err_nxt;
         r_valid    <= w_valid_nxt;
         r_halted   <= w_halted_nxt;
      end
   end

   assign mem_req_o     = r_req;
   assign mem_addr_o    = r_addr;
   assign instr_valid_o = r_valid;
   assign pc_o          = r_pc;
   assign icode_o       = r_icode;
   assign ifun_o        = r_ifun;
   assign rA_o          = r_ra;
   assign rB_o          = r_rb;
   assign valC_o        = r_valc;
   assign valP_o        = r_valp;
   assign illegal_o     = r_illegal;
   assign halted_o      = r_halted;
   assign dbg_state_o   = r_state;
`ifdef IMEM_BOUND_CHECK_EN
   assign imem_error_o  = r_imem_err;
`else
   assign imem_error_o  = 1'b0;
`endif

endmodule
